// File: rtl/integer_divider.sv
// Sequential unsigned restoring shift-subtract divider with a carry-lookahead subtractor.
// Optional macro INTEGER_DIVIDER_ZERO_CHECK_EN short-circuits division by zero and raises div_by_zero.

module carry_lookahead_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W:0]   result_o
);

  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   carry;
  logic         chainProp;
  logic         carryAcc;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Each carry is formed directly from generate/propagate terms rather than rippling.
  always_comb begin
    carry     = '0;
    chainProp = 1'b0;
    carryAcc  = 1'b0;
    carry[0]  = cin_i;
    for (int i = 0; i < W; i++) begin
      carryAcc  = gen[i];
      chainProp = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        carryAcc  = carryAcc | (chainProp & gen[j]);
        chainProp = chainProp & prop[j];
      end
      carry[i+1] = carryAcc | (chainProp & cin_i);
    end
  end

  assign result_o = {carry[W], prop ^ carry[W-1:0]};

endmodule

module integer_divider #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    INITIALIZE,
    SHIFT,
    SUBTRACT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2*N:0]    shift_q, shift_d;
  logic [N-1:0]    dvsr_q, dvsr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N+1:0]    diff;

  // diff[N+1] is the carry out: set when the partial remainder is not below the divisor.
  carry_lookahead_adder #(
    .W(N + 1)
  ) u_sub (
    .a_i     (shift_q[2*N:N]),
    .b_i     (~{1'b0, dvsr_q}),
    .cin_i   (1'b1),
    .result_o(diff)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      dvsr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = INITIALIZE;
      end
      INITIALIZE: begin
        shift_d = {{(N + 1){1'b0}}, dividend};
        dvsr_d  = divisor;
        count_d = '0;
        state_d = SHIFT;
`ifdef INTEGER_DIVIDER_ZERO_CHECK_EN
        // Preload the all-ones quotient so DONE can present the result without iterating.
        if (divisor == '0) begin
          shift_d = {1'b0, dividend, {N{1'b1}}};
          state_d = DONE;
        end
`endif
      end
      SHIFT: begin
        shift_d = {shift_q[2*N-1:0], 1'b0};
        state_d = SUBTRACT;
      end
      SUBTRACT: begin
        if (diff[N+1]) begin
          shift_d[2*N:N] = diff[N:0];
          shift_d[0]     = 1'b1;
        end
        if (count_q == CW'(N - 1)) begin
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign quotient  = done ? shift_q[N-1:0] : '0;
  assign remainder = done ? shift_q[2*N-1:N] : '0;

`ifdef INTEGER_DIVIDER_ZERO_CHECK_EN
  assign div_by_zero = done && (dvsr_q == '0);
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
